spi_arbiter: RTL
================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: maximum cycles to wait for end_of_transaction before the transfer is aborted.
REQ-002 Parameter SLAVE_SEL, default 2'b10: value driven on spi_slave for every transfer.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 req  input  2  per-requester request level; bit k belongs to requester k.
REQ-006 cmd0, cmd1  input  16 each  command word ({addr,data}) of requester 0 and 1.
REQ-007 op  input  2  per-requester operation; 1 = write, 0 = read.
REQ-008 done  output  2  one-cycle completion pulse per requester.
REQ-009 err  output  2  one-cycle timeout pulse per requester, coincident with done.
REQ-010 rdata  output  8  byte captured from the SPI master, valid in the done cycle.
REQ-011 busy  output  1  high from grant until the release state ends.
REQ-012 spi_enable, spi_start  output  1 each  enable and start_transaction to the SPI master.
REQ-013 spi_slave  output  2  slave select code to the SPI master.
REQ-014 spi_data_out  output  16  outgoing_data to the SPI master.
REQ-015 spi_operation  output  1  operation to the SPI master.
REQ-016 spi_data_in  input  8  incoming_data from the SPI master.
REQ-017 spi_eot  input  1  end_of_transaction from the SPI master.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT, RELEASE, with transitions IDLE->ISSUE on any req bit, ISSUE->WAIT unconditionally, WAIT->RELEASE on spi_eot or timeout, and RELEASE->IDLE unconditionally.
REQ-019 In IDLE with one request pending, that requester SHALL be granted; with both pending, the requester not granted last SHALL win; after reset, requester 0 SHALL win.
REQ-020 On grant, cmdk and op[k] SHALL be latched into spi_data_out and spi_operation, held constant until the next grant, and later changes on the requester inputs ignored.
REQ-021 spi_enable SHALL be high in ISSUE and WAIT and low otherwise.
REQ-022 spi_start SHALL pulse high for exactly the ISSUE cycle.
REQ-023 In WAIT, spi_eot SHALL capture spi_data_in into rdata and pulse done[k] for one cycle (the RELEASE cycle).
REQ-024 A wait counter SHALL clear on ISSUE and increment each WAIT cycle.
REQ-025 When the wait counter reaches TIMEOUT_CYCLES-1 without spi_eot, the FSM SHALL enter RELEASE and pulse done[k] and err[k] together, with rdata = 8'h00.
REQ-026 If spi_eot and timeout coincide, spi_eot SHALL take precedence and no err SHALL be raised.
REQ-027 spi_eot outside WAIT SHALL be ignored.
REQ-028 Latency: req sampled in IDLE at cycle N -> ISSUE at N+1 -> done in the RELEASE cycle one cycle after spi_eot.
REQ-029 Back-to-back transfers SHALL be separated by at least one spi_enable-low cycle (RELEASE plus IDLE).
REQ-030 Requesters SHALL hold req until done; a req bit still high at the IDLE following its own done SHALL start a new transfer.
REQ-031 A req dropped before grant SHALL NOT be served.
REQ-032 A req dropped after grant SHALL NOT abort the transfer in flight.

Reset
REQ-033 reset_n low SHALL force IDLE, last-grant pointer to requester 1, and wait counter to 0.
REQ-034 reset_n low SHALL force done, err, rdata, busy, spi_enable, spi_start, spi_data_out and spi_operation to 0.
REQ-035 Reset asserted mid-transfer SHALL drop spi_enable the next edge and emit no done.

Structure
REQ-036 State encodings and the op codes WRITE = 1, READ = 0 SHALL live in shared package spi_arb_pkg.
REQ-037 Round-robin selection SHALL be the sub-module rr_arbiter2 (inputs req[1:0], last; output grant one-hot).
REQ-038 The wait counter width SHALL be $clog2(TIMEOUT_CYCLES).

Verification
REQ-039 Single write: req=01, cmd0=16'h1305, op0=1; model eot after 40 cycles -> one spi_start pulse, spi_data_out=16'h1305, done=01 one cycle after eot, err=00.
REQ-040 Contention: req=11 from reset -> requester 0 served first, then requester 1, with at least one spi_enable-low cycle between transfers.
REQ-041 Read capture: req=10, op1=0, model returns spi_data_in=8'hA5 with eot -> rdata=8'hA5 while done=10.
REQ-042 Timeout: TIMEOUT_CYCLES=16, no eot -> done=01 and err=01 on the 17th cycle after ISSUE, rdata=00, FSM returns to IDLE.
REQ-043 Reset mid-WAIT: reset_n low for 1 cycle -> spi_enable=0 next cycle, no done pulse, all outputs 0.
REQ-044 Coincidence: eot on the timeout cycle -> err=00 and rdata = captured byte.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types for the two-requester SPI arbiter: FSM state encoding and operation codes.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWait    = 2'd2,
    StRelease = 2'd3
  } state_e;

  localparam logic OpWrite = 1'b1;
  localparam logic OpRead  = 1'b0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: a lone request wins outright; on a tie the requester
// that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between two requesters: grants, issues one transaction,
// waits for end-of-transaction or timeout, then reports done/err to the owner.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [1:0]  SLAVE_SEL      = 2'b10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [15:0] cmd0,
  input  logic [15:0] cmd1,
  input  logic [1:0]  op,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        spi_enable,
  output logic        spi_start,
  output logic [1:0]  spi_slave,
  output logic [15:0] spi_data_out,
  output logic        spi_operation,
  input  logic [7:0]  spi_data_in,
  input  logic        spi_eot
);

  localparam int unsigned    CntW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              last_q, last_d;  // index of the current/most recent owner
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [15:0]       data_q, data_d;
  logic              oper_q, oper_d;
  logic [1:0]        grant;

  rr_arbiter2 u_rr (
    .req   (req),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    done_d  = 2'b00;
    err_d   = 2'b00;
    rdata_d = rdata_q;
    data_d  = data_q;
    oper_d  = oper_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StIssue;
          last_d  = grant[1];
          data_d  = grant[1] ? cmd1 : cmd0;
          oper_d  = op[grant[1]] ? OpWrite : OpRead;
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // End-of-transaction wins over a coinciding timeout.
        if (spi_eot) begin
          state_d        = StRelease;
          rdata_d        = spi_data_in;
          done_d[last_q] = 1'b1;
        end else if (cnt_q == CntMax) begin
          state_d        = StRelease;
          rdata_d        = 8'h00;
          done_d[last_q] = 1'b1;
          err_d[last_q]  = 1'b1;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= 8'h00;
      data_q  <= 16'h0000;
      oper_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      data_q  <= data_d;
      oper_q  <= oper_d;
    end
  end

  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign busy          = (state_q != StIdle);
  assign spi_enable    = (state_q == StIssue) || (state_q == StWait);
  assign spi_start     = (state_q == StIssue);
  assign spi_slave     = SLAVE_SEL;
  assign spi_data_out  = data_q;
  assign spi_operation = oper_q;

endmodule
